data_bus_arbiter: RTL and testbench

Arbitrates the single DataBusControl port between two requesters: port 0 is the core load/store path, port 1 is the program loader/debug master. The block serialises one transaction at a time and drives the DataBusControl strobes, address, size and write data. It checks alignment before issuing, and aborts transactions that stall past a timeout. It sits between the core and DataBusControl and reports its result through a per-port ack/err pulse.

---
 rtl/data_bus_arbiter_pkg.sv | 27 ++
 rtl/data_bus_arbiter_if.sv | 52 +++++
 rtl/data_bus_arbiter_rr.sv | 18 +
 rtl/data_bus_arbiter.sv | 122 ++++++++++++
 tb/tb_data_bus_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_bus_arbiter_pkg.sv
// Shared types and helpers for the two-port DataBusControl arbiter.
package data_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;

   // Size code 11 is never a legal access, so it falls through as misaligned.
   function automatic logic misaligned(
      input logic [1:0] size,
      input logic [1:0] lsb
   );
      logic ok;
      ok = (size == SIZE_B)
         || (size == SIZE_H && !lsb[0])
         || (size == SIZE_W && lsb == 2'b00);
      return !ok;
   endfunction

endpackage

// File: rtl/data_bus_arbiter_if.sv
// Requester, DataBusControl and status signals of the data bus arbiter.
interface data_bus_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  p0_req;
   logic                  p0_we;
   logic [1:0]            p0_size;
   logic [ADDR_WIDTH-1:0] p0_addr;
   logic [DATA_WIDTH-1:0] p0_wdata;
   logic                  p0_ack;
   logic                  p0_err;

   logic                  p1_req;
   logic                  p1_we;
   logic [1:0]            p1_size;
   logic [ADDR_WIDTH-1:0] p1_addr;
   logic [DATA_WIDTH-1:0] p1_wdata;
   logic                  p1_ack;
   logic                  p1_err;

   logic [DATA_WIDTH-1:0] rdata;
   logic                  bus_wd;
   logic                  bus_rd;
   logic [1:0]            bus_size;
   logic [ADDR_WIDTH-1:0] bus_addr;
   logic [DATA_WIDTH-1:0] bus_wdata;
   logic [DATA_WIDTH-1:0] bus_rdata;
   logic                  bus_ready;
   logic                  bus_busy;
   logic                  busy;
   logic                  owner;

   modport slave (
      input  p0_req, p0_we, p0_size, p0_addr, p0_wdata,
      input  p1_req, p1_we, p1_size, p1_addr, p1_wdata,
      input  bus_rdata, bus_ready, bus_busy,
      output p0_ack, p0_err, p1_ack, p1_err, rdata,
      output bus_wd, bus_rd, bus_size, bus_addr, bus_wdata,
      output busy, owner
   );

   modport master (
      output p0_req, p0_we, p0_size, p0_addr, p0_wdata,
      output p1_req, p1_we, p1_size, p1_addr, p1_wdata,
      output bus_rdata, bus_ready, bus_busy,
      input  p0_ack, p0_err, p1_ack, p1_err, rdata,
      input  bus_wd, bus_rd, bus_size, bus_addr, bus_wdata,
      input  busy, owner
   );

endinterface

// File: rtl/data_bus_arbiter_rr.sv
// Two-input arbiter: round-robin on last grant, or fixed port-0 priority.
module rr_arbiter2 (
   input  logic [1:0] i_req,
   input  logic       i_last,
   input  logic       i_fixed,
   output logic       o_gnt,
   output logic       o_valid
);

   always_comb begin
      o_valid = |i_req;
      o_gnt   = i_req[1];
      if (&i_req) begin
         o_gnt = i_fixed ? 1'b0 : ~i_last;
      end
   end

endmodule

// File: rtl/data_bus_arbiter.sv
// Serialises port 0 (core) and port 1 (loader/debug) onto DataBusControl,
// with alignment check and WAIT timeout.
module data_bus_arbiter
   import data_bus_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 16,
   parameter int FIXED_PRIO = 0
) (
   input  logic              clk,
   input  logic              rst,
   data_bus_arbiter_if.slave bif
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

   state_t                r_state;
   state_t                w_next;
   logic                  r_we;
   logic [1:0]            r_size;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic                  r_owner;
   logic                  r_last;
   logic                  r_err;
   logic [CW-1:0]         r_cnt;

   logic                  w_gnt;
   logic                  w_valid;
   logic                  w_take;
   logic                  w_mis;
   logic                  w_tmo;
   logic                  w_we;
   logic [1:0]            w_size;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [DATA_WIDTH-1:0] w_wdata;

   rr_arbiter2 u_arb (
      .i_req   ({bif.p1_req, bif.p0_req}),
      .i_last  (r_last),
      .i_fixed (FIXED_PRIO != 0),
      .o_gnt   (w_gnt),
      .o_valid (w_valid)
   );

   assign w_we    = w_gnt ? bif.p1_we    : bif.p0_we;
   assign w_size  = w_gnt ? bif.p1_size  : bif.p0_size;
   assign w_addr  = w_gnt ? bif.p1_addr  : bif.p0_addr;
   assign w_wdata = w_gnt ? bif.p1_wdata : bif.p0_wdata;
   assign w_mis   = misaligned(w_size, w_addr[1:0]);
   assign w_take  = bif.bus_ready && w_valid;
   assign w_tmo   = (r_cnt == CNT_MAX);

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE:  if (w_take) w_next = w_mis ? ST_RESP : ST_ISSUE;
         ST_ISSUE: w_next = ST_WAIT;
         ST_WAIT:  if (!bif.bus_busy || w_tmo) w_next = ST_RESP;
         ST_RESP:  w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_we    <= 1'b0;
         r_size  <= SIZE_B;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_owner <= 1'b1;
         r_last  <= 1'b1;
         r_err   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            ST_IDLE: begin
               if (w_take) begin
                  r_we    <= w_we;
                  r_size  <= w_size;
                  r_addr  <= w_addr;
                  r_wdata <= w_wdata;
                  r_owner <= w_gnt;
                  r_err   <= w_mis;
               end
            end
            ST_ISSUE: r_cnt <= '0;
            ST_WAIT: begin
               r_cnt <= r_cnt + 1'b1;
               if (!bif.bus_busy) begin
                  r_err <= 1'b0;
                  if (!r_we) r_rdata <= bif.bus_rdata;
               end else if (w_tmo) begin
                  r_err <= 1'b1;
               end
            end
            ST_RESP: r_last <= r_owner;
            default: ;
         endcase
      end
   end

   assign bif.bus_wd    = (r_state == ST_ISSUE) &&  r_we;
   assign bif.bus_rd    = (r_state == ST_ISSUE) && !r_we;
   assign bif.bus_size  = r_size;
   assign bif.bus_addr  = r_addr;
   assign bif.bus_wdata = r_wdata;
   assign bif.rdata     = r_rdata;
   assign bif.busy      = (r_state != ST_IDLE);
   assign bif.owner     = r_owner;
   assign bif.p0_ack    = (r_state == ST_RESP) && !r_owner;
   assign bif.p1_ack    = (r_state == ST_RESP) &&  r_owner;
   assign bif.p0_err    = bif.p0_ack && r_err;
   assign bif.p1_err    = bif.p1_ack && r_err;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter: round-robin/timeout instance
// plus a fixed-priority instance.
module tb_data_bus_arbiter;

   logic clk;
   logic rst;
   int   n_run;
   int   n_fail;

   data_bus_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bif ();
   data_bus_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) fif ();

   data_bus_arbiter #(.TIMEOUT(4), .FIXED_PRIO(0)) dut (
      .clk (clk),
      .rst (rst),
      .bif (bif)
   );

   data_bus_arbiter #(.TIMEOUT(4), .FIXED_PRIO(1)) dut_fp (
      .clk (clk),
      .rst (rst),
      .bif (fif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic clear_inputs;
      bif.p0_req = 0; bif.p0_we = 0; bif.p0_size = 0;
      bif.p0_addr = 0; bif.p0_wdata = 0;
      bif.p1_req = 0; bif.p1_we = 0; bif.p1_size = 0;
      bif.p1_addr = 0; bif.p1_wdata = 0;
      bif.bus_rdata = 0; bif.bus_ready = 1; bif.bus_busy = 0;
      fif.p0_req = 0; fif.p0_we = 0; fif.p0_size = 0;
      fif.p0_addr = 0; fif.p0_wdata = 0;
      fif.p1_req = 0; fif.p1_we = 0; fif.p1_size = 0;
      fif.p1_addr = 0; fif.p1_wdata = 0;
      fif.bus_rdata = 0; fif.bus_ready = 1; fif.bus_busy = 0;
   endtask

   task automatic do_reset;
      rst = 0;
      repeat (2) tick();
      rst = 1;
      tick();
   endtask

   task automatic test_reset;
      rst = 0;
      tick();
      n_run++;
      if ({bif.busy, bif.p0_ack, bif.p0_err, bif.p1_ack, bif.p1_err,
           bif.bus_wd, bif.bus_rd} !== 7'b0) begin
         n_fail++;
         $display("FAIL rst_ctrl got=%b want=0000000",
            {bif.busy, bif.p0_ack, bif.p0_err, bif.p1_ack, bif.p1_err,
             bif.bus_wd, bif.bus_rd});
      end
      n_run++;
      if ({bif.bus_addr, bif.bus_wdata, bif.rdata} !== 96'h0) begin
         n_fail++;
         $display("FAIL rst_data got=%h %h %h want=0",
            bif.bus_addr, bif.bus_wdata, bif.rdata);
      end
      n_run++;
      if (bif.bus_size !== 2'b00) begin
         n_fail++;
         $display("FAIL rst_size got=%b want=00", bif.bus_size);
      end
      n_run++;
      if (bif.owner !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_owner got=%b want=1", bif.owner);
      end
      rst = 1;
      tick();
   endtask

   task automatic test_contention;
      logic       exp;
      logic [1:0] exp_ack;
      do_reset();
      bif.p0_we = 1; bif.p0_size = 2'b10;
      bif.p0_addr = 32'h0; bif.p0_wdata = 32'h11;
      bif.p1_we = 1; bif.p1_size = 2'b10;
      bif.p1_addr = 32'h4; bif.p1_wdata = 32'h22;
      bif.p0_req = 1; bif.p1_req = 1;
      for (int i = 0; i < 4; i++) begin
         exp = i[0];
         exp_ack = exp ? 2'b10 : 2'b01;
         tick();
         n_run++;
         if ({bif.bus_wd, bif.owner} !== {1'b1, exp}) begin
            n_fail++;
            $display("FAIL rr_issue%0d wd/owner got=%b%b want=1%b",
               i, bif.bus_wd, bif.owner, exp);
         end
         n_run++;
         if (bif.bus_wdata !== (exp ? 32'h22 : 32'h11)) begin
            n_fail++;
            $display("FAIL rr_wdata%0d got=%h want=%h",
               i, bif.bus_wdata, exp ? 32'h22 : 32'h11);
         end
         tick();
         tick();
         n_run++;
         if ({bif.p1_ack, bif.p0_ack} !== exp_ack) begin
            n_fail++;
            $display("FAIL rr_ack%0d got=%b want=%b",
               i, {bif.p1_ack, bif.p0_ack}, exp_ack);
         end
         tick();
         n_run++;
         if ({bif.busy, bif.p1_ack, bif.p0_ack} !== 3'b000) begin
            n_fail++;
            $display("FAIL rr_idle%0d got=%b want=000",
               i, {bif.busy, bif.p1_ack, bif.p0_ack});
         end
      end
      bif.p0_req = 0; bif.p1_req = 0;
      tick();
   endtask

   task automatic test_single;
      bif.p0_we = 0; bif.p0_size = 2'b10; bif.p0_addr = 32'h100;
      bif.bus_rdata = 32'hDEADBEEF; bif.bus_busy = 0;
      bif.p0_req = 1;
      tick();
      n_run++;
      if ({bif.bus_rd, bif.bus_wd} !== 2'b10 ||
          bif.bus_addr !== 32'h100) begin
         n_fail++;
         $display("FAIL single_issue rd/wd=%b addr=%h want 10 00000100",
            {bif.bus_rd, bif.bus_wd}, bif.bus_addr);
      end
      tick();
      n_run++;
      if ({bif.bus_rd, bif.p0_ack} !== 2'b00) begin
         n_fail++;
         $display("FAIL single_wait got=%b want=00",
            {bif.bus_rd, bif.p0_ack});
      end
      tick();
      n_run++;
      if ({bif.p0_ack, bif.p0_err, bif.p1_ack} !== 3'b100) begin
         n_fail++;
         $display("FAIL single_ack got=%b want=100",
            {bif.p0_ack, bif.p0_err, bif.p1_ack});
      end
      n_run++;
      if (bif.rdata !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL single_rdata got=%h want=deadbeef", bif.rdata);
      end
      bif.p0_req = 0;
      tick();
      n_run++;
      if ({bif.busy, bif.p0_ack} !== 2'b00) begin
         n_fail++;
         $display("FAIL single_done got=%b want=00",
            {bif.busy, bif.p0_ack});
      end
   endtask

   task automatic test_not_ready;
      bif.bus_ready = 0;
      bif.p1_we = 0; bif.p1_size = 2'b10; bif.p1_addr = 32'h10;
      bif.p1_req = 1;
      tick();
      tick();
      n_run++;
      if ({bif.busy, bif.bus_rd} !== 2'b00) begin
         n_fail++;
         $display("FAIL not_ready got=%b want=00",
            {bif.busy, bif.bus_rd});
      end
      bif.p1_req = 0;
      bif.bus_ready = 1;
      tick();
   endtask

   task automatic test_misaligned;
      bif.p1_we = 1; bif.p1_size = 2'b01;
      bif.p1_addr = 32'h103; bif.p1_wdata = 32'h55;
      bif.p1_req = 1;
      tick();
      n_run++;
      if ({bif.p1_ack, bif.p1_err, bif.p0_ack} !== 3'b110) begin
         n_fail++;
         $display("FAIL mis_ack got=%b want=110",
            {bif.p1_ack, bif.p1_err, bif.p0_ack});
      end
      n_run++;
      if (bif.bus_wd !== 1'b0) begin
         n_fail++;
         $display("FAIL mis_wd_resp got=%b want=0", bif.bus_wd);
      end
      bif.p1_req = 0;
      tick();
      n_run++;
      if ({bif.busy, bif.bus_wd, bif.p1_ack} !== 3'b000) begin
         n_fail++;
         $display("FAIL mis_idle got=%b want=000",
            {bif.busy, bif.bus_wd, bif.p1_ack});
      end
   endtask

   task automatic test_timeout;
      bif.p0_we = 0; bif.p0_size = 2'b10; bif.p0_addr = 32'h200;
      bif.bus_rdata = 32'h12345678; bif.bus_busy = 1;
      bif.p0_req = 1;
      tick();
      n_run++;
      if (bif.bus_rd !== 1'b1) begin
         n_fail++;
         $display("FAIL tmo_issue got=%b want=1", bif.bus_rd);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         n_run++;
         if ({bif.busy, bif.p0_ack, bif.bus_rd} !== 3'b100) begin
            n_fail++;
            $display("FAIL tmo_wait%0d got=%b want=100",
               i, {bif.busy, bif.p0_ack, bif.bus_rd});
         end
      end
      tick();
      n_run++;
      if ({bif.p0_ack, bif.p0_err} !== 2'b11) begin
         n_fail++;
         $display("FAIL tmo_ack got=%b want=11",
            {bif.p0_ack, bif.p0_err});
      end
      n_run++;
      if (bif.rdata !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL tmo_rdata got=%h want=deadbeef", bif.rdata);
      end
      bif.p0_req = 0;
      bif.bus_busy = 0;
      tick();
      bif.p1_we = 0; bif.p1_size = 2'b10; bif.p1_addr = 32'h300;
      bif.bus_rdata = 32'hCAFEF00D;
      bif.p1_req = 1;
      tick();
      n_run++;
      if (bif.bus_rd !== 1'b1 || bif.bus_addr !== 32'h300) begin
         n_fail++;
         $display("FAIL tmo_next_issue rd=%b addr=%h want 1 00000300",
            bif.bus_rd, bif.bus_addr);
      end
      tick();
      tick();
      n_run++;
      if ({bif.p1_ack, bif.p1_err} !== 2'b10 ||
          bif.rdata !== 32'hCAFEF00D) begin
         n_fail++;
         $display("FAIL tmo_next_ack ack/err=%b rdata=%h want 10 cafef00d",
            {bif.p1_ack, bif.p1_err}, bif.rdata);
      end
      bif.p1_req = 0;
      tick();
   endtask

   task automatic test_reset_mid;
      bif.p0_we = 0; bif.p0_size = 2'b10; bif.p0_addr = 32'h400;
      bif.bus_busy = 1;
      bif.p0_req = 1;
      tick();
      tick();
      n_run++;
      if (bif.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL rmid_wait got=%b want=1", bif.busy);
      end
      #2 rst = 0;
      #1;
      n_run++;
      if ({bif.busy, bif.bus_rd, bif.bus_wd, bif.p0_ack} !== 4'b0) begin
         n_fail++;
         $display("FAIL rmid_async got=%b want=0000",
            {bif.busy, bif.bus_rd, bif.bus_wd, bif.p0_ack});
      end
      tick();
      n_run++;
      if (bif.p0_ack !== 1'b0) begin
         n_fail++;
         $display("FAIL rmid_noack got=%b want=0", bif.p0_ack);
      end
      bif.bus_busy = 0;
      rst = 1;
      tick();
      n_run++;
      if (bif.bus_rd !== 1'b1 || bif.bus_addr !== 32'h400 ||
          bif.owner !== 1'b0) begin
         n_fail++;
         $display("FAIL rmid_regrant rd=%b addr=%h owner=%b want 1 400 0",
            bif.bus_rd, bif.bus_addr, bif.owner);
      end
      tick();
      tick();
      n_run++;
      if ({bif.p0_ack, bif.p0_err} !== 2'b10) begin
         n_fail++;
         $display("FAIL rmid_ack got=%b want=10",
            {bif.p0_ack, bif.p0_err});
      end
      bif.p0_req = 0;
      tick();
   endtask

   task automatic test_fixed_prio;
      fif.p0_we = 1; fif.p0_size = 2'b10;
      fif.p0_addr = 32'h0; fif.p0_wdata = 32'h11;
      fif.p1_we = 1; fif.p1_size = 2'b10;
      fif.p1_addr = 32'h4; fif.p1_wdata = 32'h22;
      fif.p0_req = 1; fif.p1_req = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_run++;
         if (fif.owner !== 1'b0 || fif.bus_wdata !== 32'h11) begin
            n_fail++;
            $display("FAIL fp_issue%0d owner=%b wdata=%h want 0 11",
               i, fif.owner, fif.bus_wdata);
         end
         tick();
         tick();
         n_run++;
         if ({fif.p1_ack, fif.p0_ack} !== 2'b01) begin
            n_fail++;
            $display("FAIL fp_ack%0d got=%b want=01",
               i, {fif.p1_ack, fif.p0_ack});
         end
         tick();
      end
      fif.p0_req = 0; fif.p1_req = 0;
      tick();
   endtask

   initial begin
      n_run = 0;
      n_fail = 0;
      rst = 0;
      clear_inputs();
      test_reset();
      test_contention();
      test_single();
      test_not_ready();
      test_misaligned();
      test_timeout();
      test_reset_mid();
      test_fixed_prio();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
